// File: rtl/alu_rr_scheduler_pkg.sv
// Shared constants and types for the round-robin ALU scheduler.
package alu_rr_scheduler_pkg;
    localparam int OPW = 4;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    typedef struct packed {
        logic [2:0]     sel;
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
    } alu_op_t;
endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Two requester channels plus the response channel of the scheduler.
interface alu_rr_scheduler_if;
    import alu_rr_scheduler_pkg::*;

    logic           req0_valid, req0_ready;
    logic [2:0]     req0_sel;
    logic [OPW-1:0] req0_a, req0_b;
    logic           req1_valid, req1_ready;
    logic [2:0]     req1_sel;
    logic [OPW-1:0] req1_a, req1_b;
    logic           rsp_valid, rsp_ready, rsp_id, rsp_carry;
    logic [OPW-1:0] rsp_data;

    modport master (
        output req0_valid, req0_sel, req0_a, req0_b, input req0_ready,
        output req1_valid, req1_sel, req1_a, req1_b, input req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_carry, output rsp_ready
    );
    modport slave (
        input  req0_valid, req0_sel, req0_a, req0_b, output req0_ready,
        input  req1_valid, req1_sel, req1_a, req1_b, output req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_carry, input rsp_ready
    );
endinterface

// File: rtl/alu_rr_scheduler_alu.sv
// Combinational 4-bit ALU; carry is meaningful for add (carry-out) and sub (borrow) only.
module alu_4bit_mux
    import alu_rr_scheduler_pkg::*;
(
    input  logic [2:0]     sel,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [OPW-1:0] y,
    output logic           carry
);
    logic [OPW:0] sum, diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        y     = '0;
        carry = 1'b0;
        case (sel)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_ADD: begin y = sum[OPW-1:0];  carry = sum[OPW];  end
            OP_SUB: begin y = diff[OPW-1:0]; carry = diff[OPW]; end
            OP_NOT: y = ~a;
            OP_SHL: y = {b[OPW-2:0], 1'b0};
            OP_SHR: y = {1'b0, b[OPW-1:1]};
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/alu_rr_scheduler.sv
// Two-requester round-robin front end for a single shared ALU.
// One operation in flight: IDLE accepts, EXEC computes, RESP holds the result.
module alu_rr_scheduler
    import alu_rr_scheduler_pkg::*;
#(
    parameter int FIRST_PRIO = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_rr_scheduler_if.slave  bus,
    output logic               busy
);
    state_t         state;
    logic           ptr, gnt, acc;
    alu_op_t        op_q;
    logic           id_q;
    logic [OPW-1:0] alu_y, data_q;
    logic           alu_c, carry_q, rid_q;

    // Pointer only arbitrates a tie; a lone requester always wins.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) gnt = ptr;
        else                                  gnt = bus.req1_valid;
    end

    assign acc            = rst_n && (state == ST_IDLE) && (bus.req0_valid || bus.req1_valid);
    assign bus.req0_ready = acc && !gnt;
    assign bus.req1_ready = acc &&  gnt;

    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_id    = rid_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_carry = carry_q;
    assign busy          = (state != ST_IDLE);

    alu_4bit_mux u_alu (
        .sel   (op_q.sel),
        .a     (op_q.a),
        .b     (op_q.b),
        .y     (alu_y),
        .carry (alu_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ptr     <= 1'(FIRST_PRIO);
            op_q    <= '0;
            id_q    <= 1'b0;
            rid_q   <= 1'b0;
            data_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (acc) begin
                    op_q  <= gnt ? alu_op_t'{bus.req1_sel, bus.req1_a, bus.req1_b}
                                 : alu_op_t'{bus.req0_sel, bus.req0_a, bus.req0_b};
                    id_q  <= gnt;
                    ptr   <= ~gnt;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    data_q  <= alu_y;
                    carry_q <= alu_c;
                    rid_q   <= id_q;
                    state   <= ST_RESP;
                end
                ST_RESP: if (bus.rsp_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
